// File: rtl/gray_counter_cfg.sv
// gray_counter_cfg
//   Parametrised up/down counter holding both a binary and a Gray-coded copy
//   of the count, each in its own flop bank. The Gray bank is loaded from the
//   next-state binary value, so gray_out never passes through decode logic
//   after the clock edge and is safe to sample from another clock domain.
//
// Parameters
//   WIDTH      counter width, 2..32
//   RESET_VAL  binary value taken on reset, must fit in WIDTH bits
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   en            count enable, one step per cycle
//   up_dn         1 = count up, 0 = count down
//   load          synchronous parallel load, takes priority over en
//   load_is_gray  1 = load_val is Gray-coded, 0 = binary
//   load_val      value to load
//   bin_out       registered binary count
//   gray_out      registered Gray count (bin_out ^ (bin_out >> 1))
//   tc            registered terminal-count pulse
//
// Build option
//   GRAY_CNT_SATURATE_EN  when defined the counter saturates at all-ones / zero
//                         instead of wrapping; tc marks the step that reaches
//                         the limit. Undefined (default) gives modulo wrap.

module gray_counter_cfg #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RST_BIN  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_tc;

  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;
  logic             w_tc_nxt;
  logic             w_at_max;
  logic             w_at_min;

  // Prefix XOR from the MSB down: b[i] = b[i+1] ^ g[i].
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign w_at_max = (r_bin == ALL_ONES);
  assign w_at_min = (r_bin == '0);

  always_comb begin
    w_bin_nxt = r_bin;
    w_tc_nxt  = 1'b0;
    if (load) begin
      w_bin_nxt = load_is_gray ? gray2bin(load_val) : load_val;
    end else if (en) begin
      if (up_dn) begin
`ifdef GRAY_CNT_SATURATE_EN
        // Pinned at the limit: hold without re-flagging tc.
        if (!w_at_max) begin
          w_bin_nxt = r_bin + ONE;
          w_tc_nxt  = (r_bin == (ALL_ONES - ONE));
        end
`else
        w_bin_nxt = r_bin + ONE;
        w_tc_nxt  = w_at_max;
`endif
      end else begin
`ifdef GRAY_CNT_SATURATE_EN
        if (!w_at_min) begin
          w_bin_nxt = r_bin - ONE;
          w_tc_nxt  = (r_bin == ONE);
        end
`else
        w_bin_nxt = r_bin - ONE;
        w_tc_nxt  = w_at_min;
`endif
      end
    end
  end

  assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= RST_BIN;
      r_gray <= RST_GRAY;
      r_tc   <= 1'b0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
      r_tc   <= w_tc_nxt;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign tc       = r_tc;

endmodule

// File: tb/tb_gray_counter_cfg.sv
module tb_gray_counter_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       load = 1'b0;
  logic       load_is_gray = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] bin_out, gray_out;
  logic       tc;
  logic [3:0] bin5, gray5;
  logic       tc5;

  gray_counter_cfg #(.WIDTH(4), .RESET_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val),
    .bin_out(bin_out), .gray_out(gray_out), .tc(tc)
  );

  gray_counter_cfg #(.WIDTH(4), .RESET_VAL(5)) dut5 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val),
    .bin_out(bin5), .gray_out(gray5), .tc(tc5)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] bin;
    logic [3:0] gray;
    logic       tc;
    bit         step;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] prev_gray = '0;

  // Hand-written Gray sequence for a 4-bit up count starting at 0.
  logic [3:0] gseq [0:16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                              4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101,
                              4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001,
                              4'b1000, 4'b0000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic lg, input logic [3:0] lv,
                       input logic e, input logic u,
                       input logic [3:0] eb, input logic [3:0] eg, input logic et,
                       input string nm);
    exp_t x;
    @(negedge clk);
    load = ld; load_is_gray = lg; load_val = lv; en = e; up_dn = u;
    x.bin = eb; x.gray = eg; x.tc = et; x.step = e && !ld; x.name = nm;
    q.push_back(x);
  endtask

  always @(negedge clk) prev_gray = gray_out;

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m_e = q.pop_front();
      chk({m_e.name, " bin"},  32'(bin_out),  32'(m_e.bin));
      chk({m_e.name, " gray"}, 32'(gray_out), 32'(m_e.gray));
      chk({m_e.name, " tc"},   32'(tc),       32'(m_e.tc));
      if (m_e.step && gray_out !== prev_gray)
        chk({m_e.name, " onebit"}, 32'($countones(gray_out ^ prev_gray)), 32'd1);
    end
  end

  task automatic wait_drain(input string nm);
    int k;
    k = 0;
    while (q.size() > 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #2;
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: %0d expectations left, expected 0", nm, q.size());
      q.delete();
    end
  endtask

  initial begin
    logic [3:0] eb;
    logic [3:0] eg;
    logic       et;

    #1 rst = 1'b1;
    #10;
    chk("rst0 bin", 32'(bin_out), 32'd0);
    chk("rst0 gray", 32'(gray_out), 32'd0);
    chk("rst0 tc", 32'(tc), 32'd0);
    chk("rst5 bin", 32'(bin5), 32'b0101);
    chk("rst5 gray", 32'(gray5), 32'b0111);
    chk("rst5 tc", 32'(tc5), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
`ifdef GRAY_CNT_SATURATE_EN
      eb = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      eg = gseq[eb];
      et = (i + 1 == 15);
`else
      eb = 4'(i + 1);
      eg = gseq[i+1];
      et = (eb == 4'd0);
`endif
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, eb, eg, et, $sformatf("up%0d", i));
    end

    drive(1'b1, 1'b1, 4'b1011, 1'b0, 1'b0, 4'd13, 4'b1011, 1'b0, "ld_gray");
    drive(1'b1, 1'b0, 4'b0110, 1'b1, 1'b1, 4'd6,  4'b0101, 1'b0, "ld_bin");

    drive(1'b1, 1'b0, 4'b1101, 1'b0, 1'b0, 4'd13, 4'b1011, 1'b0, "ld13");
`ifdef GRAY_CNT_SATURATE_EN
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd14, 4'b1001, 1'b0, "sat_a");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd15, 4'b1000, 1'b1, "sat_b");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd15, 4'b1000, 1'b0, "sat_c");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd15, 4'b1000, 1'b0, "sat_d");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd14, 4'b1001, 1'b0, "sat_dn");
`else
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd14, 4'b1001, 1'b0, "wrp_a");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd15, 4'b1000, 1'b0, "wrp_b");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0,  4'b0000, 1'b1, "wrp_c");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1,  4'b0001, 1'b0, "wrp_d");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0,  4'b0000, 1'b0, "wrp_dn");
`endif

    drive(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0, 4'b0000, 1'b0, "ld0");
`ifdef GRAY_CNT_SATURATE_EN
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'b0000, 1'b0, "dn_a");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'b0000, 1'b0, "dn_b");
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'b0000, 1'b0, "hold");
`else
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd15, 4'b1000, 1'b1, "dn_a");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd14, 4'b1001, 1'b0, "dn_b");
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd14, 4'b1001, 1'b0, "hold");
`endif

    drive(1'b1, 1'b0, 4'b0011, 1'b1, 1'b1, 4'd3,  4'b0010, 1'b0, "ld_wins");
    drive(1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 4'd15, 4'b1000, 1'b0, "ld15");
    drive(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 4'd0,  4'b0000, 1'b0, "ld_no_tc");

    drive(1'b1, 1'b0, 4'b0011, 1'b0, 1'b0, 4'd3, 4'b0010, 1'b0, "ld3");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd4, 4'b0110, 1'b0, "tog_a");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 4'b0010, 1'b0, "tog_b");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd4, 4'b0110, 1'b0, "tog_c");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 4'b0010, 1'b0, "tog_d");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd4, 4'b0110, 1'b0, "mid_a");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 4'b0111, 1'b0, "mid_b");
    wait_drain("drain1");

    // en stays high, so the counter is still moving when rst lands mid-cycle.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst bin", 32'(bin_out), 32'd0);
    chk("arst gray", 32'(gray_out), 32'd0);
    chk("arst tc", 32'(tc), 32'd0);
    chk("arst5 bin", 32'(bin5), 32'b0101);
    chk("arst5 gray", 32'(gray5), 32'b0111);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;

    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 4'b0001, 1'b0, "post_a");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 4'b0011, 1'b0, "post_b");
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 4'b0011, 1'b0, "post_hold");
    wait_drain("drain2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
